// File: rtl/cpu_ctrl_pkg.sv
// ============================================================================
// cpu_ctrl_pkg : shared encodings for the CPU run/halt/step sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RESET_HOLD = 2'd0,
    ST_HALTED     = 2'd1,
    ST_RUN        = 2'd2,
    ST_STEP       = 2'd3
  } state_e;

  localparam logic [1:0] HC_NONE = 2'd0;
  localparam logic [1:0] HC_SW   = 2'd1;
  localparam logic [1:0] HC_BP   = 2'd2;
  localparam logic [1:0] HC_STEP = 2'd3;

  localparam int              PHASE_W   = 3;
  localparam logic [PHASE_W-1:0] PH_REG_EN = 3'd6;
  localparam logic [PHASE_W-1:0] PH_LAST   = 3'd7;

endpackage

`default_nettype wire

// File: rtl/cpu_phase_gen.sv
// ============================================================================
// cpu_phase_gen : 8-phase divider producing cpu_clk, PC/regfile enables and
// the CPU-cycle boundary pulse.  Rev 1.0
// ============================================================================
`default_nettype none

module cpu_phase_gen
  import cpu_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic cpu_clk_o,
  output logic pc_en_o,
  output logic reg_en_o,
  output logic boundary_o
);

  logic [PHASE_W-1:0] phase_q;
  logic [PHASE_W-1:0] phase_d;

  always_comb begin
    phase_d = phase_q;
    if (en_i) begin
      phase_d = phase_q + PHASE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  // Phase always rests at 0 while disabled, so cpu_clk is naturally frozen low.
  assign cpu_clk_o  = phase_q[1];
  assign pc_en_o    = en_i && (phase_q[2:1] == 2'b00);
  assign reg_en_o   = en_i && (phase_q == PH_REG_EN);
  assign boundary_o = en_i && (phase_q == PH_LAST);

endmodule

`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
// ============================================================================
// cpu_run_ctrl : run/halt/single-step sequencer with post-reset hold,
// PC breakpoint and saturating retired-cycle counter.  Rev 1.0
// ============================================================================
`default_nettype none

module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int RST_HOLD = 16,
  parameter int PC_W     = 32,
  parameter int CNT_W    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run_sw_i,
  input  logic            step_i,
  input  logic            halt_req_i,
  input  logic            bp_en_i,
  input  logic [PC_W-1:0] bp_addr_i,
  input  logic [PC_W-1:0] pc_i,
  input  logic            cnt_clr_i,
  output logic            cpu_clk,
  output logic            pc_en_o,
  output logic            reg_en_o,
  output logic            cpu_rst_o,
  output logic [1:0]      state_o,
  output logic [1:0]      halt_cause_o,
  output logic [CNT_W-1:0] cycle_cnt_o
);

  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

  state_e             state_q, state_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               cpu_rst_q, cpu_rst_d;
  logic [1:0]         cause_q, cause_d;
  logic               bp_skip_q, bp_skip_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               step_q;

  logic active;
  logic boundary;
  logic run_go;
  logic step_rise;

  assign active    = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign run_go    = run_sw_i && !halt_req_i;
  assign step_rise = step_i && !step_q;

  cpu_phase_gen u_phase_gen (
    .clk        (clk),
    .rst        (rst),
    .en_i       (active),
    .cpu_clk_o  (cpu_clk),
    .pc_en_o    (pc_en_o),
    .reg_en_o   (reg_en_o),
    .boundary_o (boundary)
  );

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    cpu_rst_d = cpu_rst_q;
    cause_d   = cause_q;
    bp_skip_d = bp_skip_q;
    cnt_d     = cnt_q;

    case (state_q)
      ST_RESET_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          cpu_rst_d = 1'b0;
          state_d   = run_go ? ST_RUN : ST_HALTED;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ST_HALTED: begin
        if (run_go) begin
          state_d   = ST_RUN;
          bp_skip_d = 1'b1;
          cause_d   = HC_NONE;
        end else if (step_rise && !halt_req_i) begin
          state_d   = ST_STEP;
          bp_skip_d = 1'b1;
          cause_d   = HC_NONE;
        end
      end
      ST_RUN: begin
        if (boundary) begin
          bp_skip_d = 1'b0;
          if (halt_req_i || !run_sw_i) begin
            state_d = ST_HALTED;
            cause_d = HC_SW;
          end else if (bp_en_i && !bp_skip_q && (pc_i == bp_addr_i)) begin
            state_d = ST_HALTED;
            cause_d = HC_BP;
          end
        end
      end
      ST_STEP: begin
        if (boundary) begin
          bp_skip_d = 1'b0;
          state_d   = ST_HALTED;
          cause_d   = HC_STEP;
        end
      end
      default: state_d = ST_RESET_HOLD;
    endcase

    // Clear has priority over a same-clk boundary increment.
    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (boundary && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RESET_HOLD;
      hold_q    <= '0;
      cpu_rst_q <= 1'b1;
      cause_q   <= HC_NONE;
      bp_skip_q <= 1'b1;
      cnt_q     <= '0;
      step_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      cpu_rst_q <= cpu_rst_d;
      cause_q   <= cause_d;
      bp_skip_q <= bp_skip_d;
      cnt_q     <= cnt_d;
      step_q    <= step_i;
    end
  end

  assign cpu_rst_o    = cpu_rst_q;
  assign state_o      = state_q;
  assign halt_cause_o = cause_q;
  assign cycle_cnt_o  = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
// ============================================================================
// tb_cpu_run_ctrl : directed self-checking bench for cpu_run_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_cpu_run_ctrl;

  localparam int RST_HOLD = 16;
  localparam int PC_W     = 32;
  localparam int CNT_W    = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            run_sw_i;
  logic            step_i;
  logic            halt_req_i;
  logic            bp_en_i;
  logic [PC_W-1:0] bp_addr_i;
  logic [PC_W-1:0] pc_i;
  logic            cnt_clr_i;
  logic            cpu_clk;
  logic            pc_en_o;
  logic            reg_en_o;
  logic            cpu_rst_o;
  logic [1:0]      state_o;
  logic [1:0]      halt_cause_o;
  logic [CNT_W-1:0] cycle_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  cpu_run_ctrl #(
    .RST_HOLD (RST_HOLD),
    .PC_W     (PC_W),
    .CNT_W    (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .run_sw_i     (run_sw_i),
    .step_i       (step_i),
    .halt_req_i   (halt_req_i),
    .bp_en_i      (bp_en_i),
    .bp_addr_i    (bp_addr_i),
    .pc_i         (pc_i),
    .cnt_clr_i    (cnt_clr_i),
    .cpu_clk      (cpu_clk),
    .pc_en_o      (pc_en_o),
    .reg_en_o     (reg_en_o),
    .cpu_rst_o    (cpu_rst_o),
    .state_o      (state_o),
    .halt_cause_o (halt_cause_o),
    .cycle_cnt_o  (cycle_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One single-step cycle from HALTED; optionally pokes halt_req and a second
  // step edge mid-cycle, both of which must be ignored.
  task automatic do_step(input string tag, input bit extra);
    step_i = 1'b1;
    tick(1);
    check_val({tag, "_state_step"}, 32'(state_o), 32'd3);
    tick(2);
    step_i = 1'b0;
    if (extra) halt_req_i = 1'b1;
    tick(2);
    if (extra) step_i = 1'b1;
    tick(3);
    check_val({tag, "_still_step_ph7"}, 32'(state_o), 32'd3);
    tick(1);
    check_val({tag, "_halted"}, 32'(state_o), 32'd1);
    check_val({tag, "_cause"}, 32'(halt_cause_o), 32'd3);
    step_i     = 1'b0;
    halt_req_i = 1'b0;
    tick(12);
    check_val({tag, "_stays_halted"}, 32'(state_o), 32'd1);
  endtask

  initial begin
    int n;
    rst        = 1'b1;
    run_sw_i   = 1'b1;
    step_i     = 1'b0;
    halt_req_i = 1'b0;
    bp_en_i    = 1'b0;
    bp_addr_i  = 32'h0000_0010;
    pc_i       = '0;
    cnt_clr_i  = 1'b0;
    tick(3);

    check_val("rst_state", 32'(state_o), 32'd0);
    check_val("rst_cpu_rst", 32'(cpu_rst_o), 32'd1);
    check_val("rst_cpu_clk", 32'(cpu_clk), 32'd0);
    check_val("rst_pc_en", 32'(pc_en_o), 32'd0);
    check_val("rst_cnt", 32'(cycle_cnt_o), 32'd0);
    check_val("rst_cause", 32'(halt_cause_o), 32'd0);

    // Reset hold length
    rst = 1'b0;
    n = 0;
    while (cpu_rst_o && n < 40) begin
      tick(1);
      n++;
    end
    check_val("hold_len", 32'(n), 32'd16);
    check_val("hold_to_run", 32'(state_o), 32'd2);

    // One CPU cycle waveform
    for (int p = 0; p < 8; p++) begin
      check_val($sformatf("wave_cpuclk_p%0d", p), 32'(cpu_clk), 32'((p >> 1) & 1));
      check_val($sformatf("wave_pcen_p%0d", p), 32'(pc_en_o), 32'(p < 2));
      check_val($sformatf("wave_regen_p%0d", p), 32'(reg_en_o), 32'(p == 6));
      tick(1);
    end
    check_val("cnt_after_1", 32'(cycle_cnt_o), 32'd1);

    // Drop run switch mid-cycle
    tick(2);
    run_sw_i = 1'b0;
    tick(5);
    check_val("sw_run_until_ph7", 32'(state_o), 32'd2);
    tick(1);
    check_val("sw_halted", 32'(state_o), 32'd1);
    check_val("sw_cause", 32'(halt_cause_o), 32'd1);
    check_val("sw_cnt", 32'(cycle_cnt_o), 32'd2);
    tick(3);
    check_val("sw_cpu_clk_low", 32'(cpu_clk), 32'd0);
    check_val("sw_pc_en_low", 32'(pc_en_o), 32'd0);

    // Three single steps
    do_step("step1", 1'b1);
    do_step("step2", 1'b0);
    do_step("step3", 1'b0);
    check_val("step_cnt", 32'(cycle_cnt_o), 32'd5);

    // Breakpoint
    bp_en_i  = 1'b1;
    run_sw_i = 1'b1;
    tick(1);
    check_val("bp_run_start", 32'(state_o), 32'd2);
    check_val("bp_cause_cleared", 32'(halt_cause_o), 32'd0);
    check_val("bp_first_pc_en", 32'(pc_en_o), 32'd1);
    tick(8);
    pc_i = 32'h0000_0010;
    tick(7);
    check_val("bp_run_ph7", 32'(state_o), 32'd2);
    tick(1);
    check_val("bp_halted", 32'(state_o), 32'd1);
    check_val("bp_cause", 32'(halt_cause_o), 32'd2);
    check_val("bp_cnt", 32'(cycle_cnt_o), 32'd7);
    run_sw_i = 1'b0;
    tick(2);
    check_val("bp_hold_halted", 32'(state_o), 32'd1);
    run_sw_i = 1'b1;
    tick(1);
    check_val("bp_rerun", 32'(state_o), 32'd2);
    tick(8);
    check_val("bp_skipped", 32'(state_o), 32'd2);
    check_val("bp_skip_cnt", 32'(cycle_cnt_o), 32'd8);
    tick(8);
    check_val("bp_hit_again", 32'(state_o), 32'd1);
    check_val("bp_hit_again_cause", 32'(halt_cause_o), 32'd2);
    bp_en_i = 1'b0;
    pc_i    = '0;
    tick(1);
    check_val("bp_resume", 32'(state_o), 32'd2);

    // Saturation and clear (counter width 4 here, so all-ones = 15)
    tick(64);
    check_val("cnt_saturate", 32'(cycle_cnt_o), 32'd15);
    tick(7);
    cnt_clr_i = 1'b1;
    tick(1);
    cnt_clr_i = 1'b0;
    check_val("cnt_clear_on_boundary", 32'(cycle_cnt_o), 32'd0);
    tick(8);
    check_val("cnt_after_clear", 32'(cycle_cnt_o), 32'd1);

    // Asynchronous reset at phase 5
    tick(5);
    check_val("pre_rst_running", 32'(state_o), 32'd2);
    run_sw_i = 1'b0;
    rst = 1'b1;
    #1;
    check_val("arst_state", 32'(state_o), 32'd0);
    check_val("arst_cpu_rst", 32'(cpu_rst_o), 32'd1);
    check_val("arst_cnt", 32'(cycle_cnt_o), 32'd0);
    check_val("arst_cpu_clk", 32'(cpu_clk), 32'd0);
    check_val("arst_pc_en", 32'(pc_en_o), 32'd0);
    tick(3);
    check_val("arst_cnt_held", 32'(cycle_cnt_o), 32'd0);
    rst = 1'b0;
    tick(16);
    check_val("arst_to_halted", 32'(state_o), 32'd1);
    check_val("arst_cpu_rst_off", 32'(cpu_rst_o), 32'd0);

    // halt_req blocks a run request while halted
    halt_req_i = 1'b1;
    run_sw_i   = 1'b1;
    tick(2);
    check_val("hreq_blocks_run", 32'(state_o), 32'd1);
    halt_req_i = 1'b0;
    tick(1);
    check_val("hreq_release_run", 32'(state_o), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
